mimic_mem_hs: RTL and testbench

- Parametrised successor to the 8-byte, byte-wide BRAM mimic used in the memstage bench.
- Word-wide storage with per-byte write enables and a valid/ready request side.
- Programmable response latency, so the mem stage can be exercised against slow memory as well as BRAM-like memory.
- Supports one outstanding transaction; back-to-back requests are accepted when LATENCY=1.

---
 rtl/mimic_mem_pkg.sv | 46 ++++
 rtl/mimic_mem_hs_array.sv | 32 +++
 rtl/mimic_mem_hs.sv | 145 ++++++++++++++
 tb/tb_mimic_mem_hs.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mimic_mem_pkg.sv
// Shared types and helpers for the handshaked memory mimic.
package mimic_mem_pkg;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of byte lanes in a word.
    function automatic int calc_nbytes(input int data_w);
        return data_w / 8;
    endfunction

    // Number of low byte-offset address bits ignored by the word index.
    function automatic int calc_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of stored words.
    function automatic int calc_depth(input int depth_log2);
        return 2 ** depth_log2;
    endfunction

    // Width of the latency wait counter.
    function automatic int calc_cnt_w(input int latency);
        return $clog2(latency) + 1;
    endfunction

    // True when any address bit in [lo, hi) is set, i.e. the byte address
    // lies outside the storage window whose top bit is lo-1.
    function automatic logic window_err(input logic [63:0] addr,
                                        input int          lo,
                                        input int          hi);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i < hi && addr[i]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/mimic_mem_hs_array.sv
// Word storage with per-byte-lane write enables. The read word is presented
// combinationally from the addressed entry, so whoever samples it on the same
// edge as a write sees the pre-write contents (read-first). No reset.
module mimic_mem_hs_array
    import mimic_mem_pkg::*;
#(
    parameter int NBYTES     = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic [NBYTES-1:0]       wr_be,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [NBYTES*8-1:0]     wdata,
    output logic [NBYTES*8-1:0]     rdata
);

    localparam int DEPTH = calc_depth(DEPTH_LOG2);

    logic [NBYTES-1:0][7:0] mem_q [DEPTH];

    // Per-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
                mem_q[addr][i] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mimic_mem_hs.sv
// Handshaked memory mimic: word-wide storage with byte enables, one
// outstanding transaction and a programmable response latency.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The requester must hold all req_* fields stable from
// raising req_valid until that edge; fields are only sampled at it. The
// response side has no backpressure: rsp_valid is a single-cycle pulse and
// rsp_rdata/rsp_err stay put until the next pulse.
module mimic_mem_hs
    import mimic_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 13,
    parameter int DEPTH_LOG2 = 3,
    parameter int LATENCY    = 1,
    parameter int STRICT     = 0
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output state_e                dbg_state
);

    localparam int NBYTES = calc_nbytes(DATA_W);
    localparam int OFF    = calc_off(DATA_W);
    localparam int CNT_W  = calc_cnt_w(LATENCY);
    // Counter preload for the BUSY phase; unused when LATENCY is 1.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   pend_rdata_q, pend_rdata_d;
    logic                pend_err_q, pend_err_d;

    logic                   accept;
    logic                   err_now;
    logic [DEPTH_LOG2-1:0]  word_idx;
    logic [NBYTES-1:0]      wr_be;
    logic [DATA_W-1:0]      rd_word;

    // Ready in IDLE and RESP; never while reset is held.
    assign req_ready = rsta_n && (state_q != ST_BUSY);
    assign accept    = req_valid && req_ready;

    // Upper address bits alias unless strict window checking is enabled.
    assign word_idx = req_addr[OFF+DEPTH_LOG2-1 -: DEPTH_LOG2];
    assign err_now  = (STRICT != 0) && window_err(64'(req_addr), OFF + DEPTH_LOG2, ADDR_W);

    // A write commits at the accept edge, unless it falls outside the window.
    assign wr_be = (accept && req_we && !err_now) ? req_be : '0;

    mimic_mem_hs_array #(
        .NBYTES     (NBYTES),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clka),
        .wr_be (wr_be),
        .addr  (word_idx),
        .wdata (req_wdata),
        .rdata (rd_word)
    );

    // Next-state and response-register computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rd_word;
                        rsp_err_d   = err_now;
                    end else begin
                        // Park the read-first word until the response is due.
                        state_d      = ST_BUSY;
                        cnt_d        = CNT_INIT;
                        pend_rdata_d = rd_word;
                        pend_err_d   = err_now;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pend_rdata_q;
                    rsp_err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and response registers; reset drops any pending response.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mimic_mem_hs.sv
// Bench for mimic_mem_hs: instance A uses default parameters, instance B uses
// LATENCY=4 with STRICT=1. A word-level model predicts every response.
module tb_mimic_mem_hs;
    import mimic_mem_pkg::*;

    localparam int LAT_B = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
    logic [3:0]  a_req_be;
    logic [12:0] a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    state_e      a_dbg;

    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
    logic [3:0]  b_req_be;
    logic [12:0] b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    state_e      b_dbg;

    mimic_mem_hs u_dut_a (
        .clka(clk), .rsta_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .dbg_state(a_dbg)
    );

    mimic_mem_hs #(.LATENCY(LAT_B), .STRICT(1)) u_dut_b (
        .clka(clk), .rsta_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .dbg_state(b_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] a_mem [8];
    logic [31:0] b_mem [8];
    logic [31:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];
    logic        a_err_q[$];
    logic        b_err_q[$];
    int          a_due_q[$];
    int          b_due_q[$];
    int          b_busy_until = -10;
    logic [31:0] a_hold = '0, b_hold = '0;
    logic        a_hold_err = 1'b0, b_hold_err = 1'b0;
    logic [31:0] a_last_act, b_last_act;
    logic        a_last_err_act, b_last_err_act;
    bit          a_exp_v, b_exp_v;

    // Model of one accepted request: read-first word, window error, byte-lane write.
    task automatic model_accept(input int sel, input bit we, input logic [3:0] be,
                                input logic [12:0] addr, input logic [31:0] wd, input int acc);
        int   idx;
        logic err;
        idx = int'(addr >> 2) % 8;
        err = (sel == 1) && ((addr >> 5) != 0);
        if (sel == 0) begin
            a_exp_q.push_back(a_mem[idx]);
            a_err_q.push_back(1'b0);
            a_due_q.push_back(acc);
            if (we) for (int l = 0; l < 4; l++) if (be[l]) a_mem[idx][l*8 +: 8] = wd[l*8 +: 8];
        end else begin
            b_exp_q.push_back(b_mem[idx]);
            b_err_q.push_back(err);
            b_due_q.push_back(acc + LAT_B - 1);
            b_busy_until = acc + LAT_B - 2;
            if (we && !err) for (int l = 0; l < 4; l++) if (be[l]) b_mem[idx][l*8 +: 8] = wd[l*8 +: 8];
        end
    endtask

    // Monitor A: checks valid timing, readiness and response contents.
    always begin
        @(negedge clk); #2;
        a_exp_v = (a_due_q.size() > 0) && (a_due_q[0] == edge_cnt);
        chk("a_rsp_valid", a_rsp_valid, a_exp_v);
        chk("a_req_ready", a_req_ready, a_rst_n);
        chk("a_resp_state", a_dbg == ST_RESP, a_exp_v);
        if (a_exp_v) begin
            if (!$isunknown(a_exp_q[0])) begin
                chk("a_rsp_rdata", a_rsp_rdata, a_exp_q[0]);
                a_hold = a_exp_q[0];
            end else begin
                a_hold = a_rsp_rdata;
            end
            chk("a_rsp_err", a_rsp_err, a_err_q[0]);
            a_hold_err = a_err_q[0];
            a_last_act = a_rsp_rdata;
            a_last_err_act = a_rsp_err;
            void'(a_exp_q.pop_front());
            void'(a_err_q.pop_front());
            void'(a_due_q.pop_front());
        end else begin
            chk("a_rdata_hold", a_rsp_rdata, a_hold);
            chk("a_err_hold", a_rsp_err, a_hold_err);
        end
    end

    // Monitor B: same, plus the busy window implied by the latency.
    always begin
        @(negedge clk); #2;
        b_exp_v = (b_due_q.size() > 0) && (b_due_q[0] == edge_cnt);
        chk("b_rsp_valid", b_rsp_valid, b_exp_v);
        chk("b_req_ready", b_req_ready, b_rst_n && (edge_cnt > b_busy_until));
        chk("b_busy_state", b_dbg == ST_BUSY, edge_cnt <= b_busy_until);
        if (b_exp_v) begin
            if (!$isunknown(b_exp_q[0])) begin
                chk("b_rsp_rdata", b_rsp_rdata, b_exp_q[0]);
                b_hold = b_exp_q[0];
            end else begin
                b_hold = b_rsp_rdata;
            end
            chk("b_rsp_err", b_rsp_err, b_err_q[0]);
            b_hold_err = b_err_q[0];
            b_last_act = b_rsp_rdata;
            b_last_err_act = b_rsp_err;
            void'(b_exp_q.pop_front());
            void'(b_err_q.pop_front());
            void'(b_due_q.pop_front());
        end else begin
            chk("b_rdata_hold", b_rsp_rdata, b_hold);
            chk("b_err_hold", b_rsp_err, b_hold_err);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; holds the request until accepted and returns
    // at the falling edge after the accept, with req_valid still high.
    task automatic issue(input int sel, input bit we, input logic [3:0] be,
                         input logic [12:0] addr, input logic [31:0] wd, output int acc);
        bit rdy;
        bit done;
        done = 1'b0;
        acc  = -1;
        if (sel == 0) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_be = be; a_req_addr = addr; a_req_wdata = wd;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_be = be; b_req_addr = addr; b_req_wdata = wd;
        end
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            rdy = (sel == 0) ? a_req_ready : b_req_ready;
            @(posedge clk); #1;
            if (rdy) begin
                done = 1'b1;
                acc  = edge_cnt;
                model_accept(sel, we, be, addr, wd, acc);
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int sel, input int n);
        if (sel == 0) a_req_valid = 1'b0;
        else          b_req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reset B at the edge right after the current falling edge.
    task automatic reset_b_mid();
        b_req_valid = 1'b0;
        b_rst_n     = 1'b0;
        @(posedge clk); #1;
        b_exp_q.delete();
        b_err_q.delete();
        b_due_q.delete();
        b_busy_until = -10;
        b_hold       = '0;
        b_hold_err   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int          acc, acc1, acc2;
    int          acc_bb [8];
    int          cur_sel, nxt_sel;
    logic [31:0] b_init0;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_be = '0; a_req_addr = '0; a_req_wdata = '0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = '0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #2;
        chk("rst_a_rdata", a_rsp_rdata, 32'h0);
        chk("rst_a_valid", a_rsp_valid, 1'b0);
        chk("rst_a_err", a_rsp_err, 1'b0);
        chk("rst_b_rdata", b_rsp_rdata, 32'h0);
        chk("rst_a_state", a_dbg, ST_IDLE);
        chk("rst_b_state", b_dbg, ST_IDLE);
        @(negedge clk);

        // Fill every word of both instances so the model knows all contents.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 8; w++) issue(s, 1'b1, 4'hF, 13'(w * 4), $urandom, acc);
            idle(s, LAT_B + 2);
        end
        b_init0 = b_mem[0];

        // Basic write then read.
        issue(0, 1'b1, 4'hF, 13'h004, 32'hDEADBEEF, acc1);
        issue(0, 1'b0, 4'hF, 13'h004, 32'h0, acc2);
        idle(0, 3);
        chk("t1_read", a_last_act, 32'hDEADBEEF);
        chk("t1_gap", acc2 - acc1, 1);

        // Byte enables and read-first.
        issue(0, 1'b1, 4'hF, 13'h008, 32'h11223344, acc);
        issue(0, 1'b1, 4'b0101, 13'h008, 32'hAABBCCDD, acc);
        idle(0, 3);
        chk("t2_read_first", a_last_act, 32'h11223344);
        issue(0, 1'b0, 4'hF, 13'h008, 32'h0, acc);
        idle(0, 3);
        chk("t2_merged", a_last_act, 32'h11BB33DD);

        // Latency 4 with a held second request.
        issue(1, 1'b0, 4'hF, 13'h00C, 32'h0, acc1);
        issue(1, 1'b0, 4'hF, 13'h010, 32'h0, acc2);
        idle(1, LAT_B + 2);
        chk("t3_accept_gap", acc2 - acc1, LAT_B);

        // Aliasing on A, window error on B.
        issue(0, 1'b1, 4'hF, 13'h020, 32'hCAFEF00D, acc);
        issue(0, 1'b0, 4'hF, 13'h000, 32'h0, acc);
        idle(0, 3);
        chk("t4_alias", a_last_act, 32'hCAFEF00D);
        chk("t4_alias_err", a_last_err_act, 1'b0);
        issue(1, 1'b1, 4'hF, 13'h020, 32'hCAFEF00D, acc);
        idle(1, LAT_B + 2);
        chk("t4_strict_err", b_last_err_act, 1'b1);
        issue(1, 1'b0, 4'hF, 13'h000, 32'h0, acc);
        idle(1, LAT_B + 2);
        chk("t4_word0_kept", b_last_act, b_init0);
        chk("t4_word0_err", b_last_err_act, 1'b0);

        // Eight back-to-back reads at latency 1.
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 4'hF, 13'(i * 4), 32'h0, acc_bb[i]);
        idle(0, 3);
        chk("t5_b2b_span", acc_bb[7] - acc_bb[0], 7);

        // Reset right after an accepted write on B.
        issue(1, 1'b1, 4'hF, 13'h018, 32'h5A5AA5A5, acc);
        reset_b_mid();
        #2;
        chk("t6_rst_rdata", b_rsp_rdata, 32'h0);
        @(negedge clk);
        issue(1, 1'b0, 4'hF, 13'h018, 32'h0, acc);
        idle(1, LAT_B + 2);
        chk("t6_write_kept", b_last_act, 32'h5A5AA5A5);

        // Randomized mix on both instances.
        cur_sel = int'($urandom_range(0, 1));
        for (int k = 0; k < 300; k++) begin
            logic [12:0] addr;
            if (cur_sel == 0) addr = 13'($urandom_range(0, 8191));
            else if ($urandom_range(0, 3) == 0) addr = 13'($urandom_range(0, 8191));
            else addr = 13'($urandom_range(0, 31));
            issue(cur_sel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom, acc);
            nxt_sel = int'($urandom_range(0, 1));
            if (nxt_sel != cur_sel || $urandom_range(0, 2) == 0) idle(cur_sel, int'($urandom_range(1, 2)));
            cur_sel = nxt_sel;
        end
        idle(0, 0);
        idle(1, LAT_B + 4);
        chk("a_drain", a_due_q.size(), 0);
        chk("b_drain", b_due_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
